alu_core: RTL and testbench



---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_shifter.sv | 29 ++
 rtl/alu_core.sv | 60 ++++++
 tb/tb_alu_core.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: data width and opcode encodings.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

endpackage

// File: rtl/alu_shifter.sv
// Five-stage combinational right barrel shifter covering both logical and arithmetic shifts.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] data_i,
    input  logic [4:0]           amt_i,
    input  logic                 arith_i,
    output logic [ALU_WIDTH-1:0] result_o
);

    logic                 fill;
    logic [ALU_WIDTH-1:0] stage1;
    logic [ALU_WIDTH-1:0] stage2;
    logic [ALU_WIDTH-1:0] stage3;
    logic [ALU_WIDTH-1:0] stage4;
    logic [ALU_WIDTH-1:0] stage5;

    // Vacated high bits take the sign only for arithmetic shifts.
    assign fill = arith_i & data_i[ALU_WIDTH-1];

    assign stage1 = amt_i[0] ? {{1{fill}},  data_i[31:1]}  : data_i;
    assign stage2 = amt_i[1] ? {{2{fill}},  stage1[31:2]}  : stage1;
    assign stage3 = amt_i[2] ? {{4{fill}},  stage2[31:4]}  : stage2;
    assign stage4 = amt_i[3] ? {{8{fill}},  stage3[31:8]}  : stage3;
    assign stage5 = amt_i[4] ? {{16{fill}}, stage4[31:16]} : stage4;

    assign result_o = stage5;

endmodule

// File: rtl/alu_core.sv
// Registered 32-bit ALU: add/sub, and/or, logical/arithmetic right shift, one-cycle latency.
module alu_core
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ALU_WIDTH-1:0] A,
    input  logic [ALU_WIDTH-1:0] B,
    input  logic [2:0]           ALUOp,
    output logic [ALU_WIDTH-1:0] C,
    output logic                 Zero
);

    logic [ALU_WIDTH-1:0] sum;
    logic [ALU_WIDTH-1:0] diff;
    logic [ALU_WIDTH-1:0] shiftResult;
    logic [ALU_WIDTH-1:0] c_d;
    logic [ALU_WIDTH-1:0] c_q;
    logic                 zero_d;
    logic                 zero_q;

    assign sum  = A + B;
    assign diff = A - B;

    alu_shifter u_shifter (
        .data_i   (A),
        .amt_i    (B[4:0]),
        .arith_i  (ALUOp == ALU_SRA),
        .result_o (shiftResult)
    );

    // Reserved opcodes fall through to zero, matching the reset value.
    always_comb begin
        c_d = '0;
        unique case (ALUOp)
            ALU_ADD: c_d = sum;
            ALU_SUB: c_d = diff;
            ALU_AND: c_d = A & B;
            ALU_OR:  c_d = A | B;
            ALU_SRL: c_d = shiftResult;
            ALU_SRA: c_d = shiftResult;
            default: c_d = '0;
        endcase
        zero_d = (c_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q    <= '0;
            zero_q <= 1'b1;
        end else begin
            c_q    <= c_d;
            zero_q <= zero_d;
        end
    end

    assign C    = c_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed and random scoreboard bench for alu_core with one-edge latency and hold checks.
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] C;
    logic        Zero;

    typedef struct {
        string       tag;
        logic [31:0] c;
        logic        z;
    } expT;

    expT         scoreboard[$];
    int          checks = 0;
    int          fails = 0;
    bit          haveLast = 0;
    logic [31:0] lastC;
    logic        lastZ;

    alu_core dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .ALUOp (ALUOp),
        .C     (C),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written directly from the operation table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a >> sh;
            3'b101:  return $unsigned($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] expC, input logic expZ);
        checks++;
        assert (C === expC && Zero === expZ)
        else begin
            fails++;
            $error("[TB] FAIL %s: C=%h Zero=%b, expected C=%h Zero=%b", tag, C, Zero, expC, expZ);
        end
    endtask

    // Drives one operation, confirms the previous result is held, then checks one edge later.
    task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op,
                                 input logic [31:0] expC);
        expT e;
        expT got;
        @(negedge clk);
        reset = rst;
        A     = a;
        B     = b;
        ALUOp = op;
        e.tag = tag;
        e.c   = rst ? 32'h0 : expC;
        e.z   = (e.c == 32'h0);
        scoreboard.push_back(e);
        #1;
        if (haveLast) checkOutput({tag, "_hold"}, lastC, lastZ);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, expected one entry", tag);
        end else begin
            got = scoreboard.pop_front();
            checkOutput(got.tag, got.c, got.z);
            lastC    = got.c;
            lastZ    = got.z;
            haveLast = 1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        reset = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        ALUOp = 3'b000;

        applyStimulus("reset",      1'b1, 32'd32,        32'd1,         3'b000, 32'h0);
        applyStimulus("add_rel",    1'b0, 32'd32,        32'd1,         3'b000, 32'd33);
        applyStimulus("sub",        1'b0, 32'd32,        32'd1,         3'b001, 32'd31);
        applyStimulus("sub_wrap",   1'b0, 32'd0,         32'd1,         3'b001, 32'hFFFFFFFF);
        applyStimulus("sub_zero",   1'b0, 32'd5,         32'd5,         3'b001, 32'h0);
        applyStimulus("add_wrap",   1'b0, 32'hFFFFFFFF,  32'd2,         3'b000, 32'd1);
        applyStimulus("and",        1'b0, 32'h0F,        32'hF1,        3'b010, 32'h01);
        applyStimulus("or",         1'b0, 32'h0F,        32'hF1,        3'b011, 32'hFF);
        applyStimulus("srl_2",      1'b0, 32'h0F,        32'd2,         3'b100, 32'h03);
        applyStimulus("sra_17",     1'b0, 32'hFFFFFF0F,  32'hF1,        3'b101, 32'hFFFFFFFF);
        applyStimulus("srl_17",     1'b0, 32'hFFFFFF0F,  32'hF1,        3'b100, 32'h00007FFF);
        applyStimulus("sra_31",     1'b0, 32'h80000000,  32'd31,        3'b101, 32'hFFFFFFFF);
        applyStimulus("srl_31",     1'b0, 32'h80000000,  32'd31,        3'b100, 32'h1);
        applyStimulus("srl_amt0",   1'b0, 32'h80000000,  32'd32,        3'b100, 32'h80000000);
        applyStimulus("sra_amt0",   1'b0, 32'h80000000,  32'd32,        3'b101, 32'h80000000);
        applyStimulus("sra_pos",    1'b0, 32'h7000_0000, 32'd4,         3'b101, 32'h0700_0000);
        applyStimulus("rsv_110",    1'b0, 32'h1234,      32'h5678,      3'b110, 32'h0);
        applyStimulus("add_mid",    1'b0, 32'h1234,      32'h5678,      3'b000, 32'h68AC);
        applyStimulus("rsv_111",    1'b0, 32'hFFFF,      32'h1,         3'b111, 32'h0);
        applyStimulus("rst_inflt",  1'b1, 32'd7,         32'd8,         3'b000, 32'h0);
        applyStimulus("after_rst",  1'b0, 32'd7,         32'd8,         3'b000, 32'd15);

        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            applyStimulus($sformatf("rand%0d_op%0d", i, rop), 1'b0, ra, rb, rop, model(ra, rb, rop));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
